mem_wb_stage: RTL and testbench

Parametrised MEM/WB pipeline stage for the MUSA core. Accepts one instruction per cycle from EX/MEM, performs byte/half/word(/dword) loads and stores over a request/ready memory port with arbitrary wait states, sign/zero-extends load data, and presents a registered writeback bundle to the register file. It adds stall back-pressure, flush, misalignment detection and a valid bit.

---
 rtl/mem_wb_if.sv | 48 ++++
 rtl/mem_wb_stage.sv | 207 ++++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_if.sv
// MEM/WB stage bundle: upstream issue, memory request/ready port and writeback outputs.
// master = the stage itself, slave = the surrounding pipeline/memory.
interface mem_wb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_AW = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_W-1:0]     in_addr;
  logic [DATA_W-1:0]     in_wdata;
  logic                  in_mem_read;
  logic                  in_mem_write;
  logic [1:0]            in_size;
  logic                  in_unsigned;
  logic [REG_AW-1:0]     in_rd;
  logic                  in_reg_write;
  logic                  flush;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_rdy;

  logic                  wb_valid;
  logic [DATA_W-1:0]     wb_data;
  logic [ADDR_W-1:0]     wb_result;
  logic [REG_AW-1:0]     wb_rd;
  logic                  wb_reg_write;
  logic                  wb_err;

  modport master (
    input  in_valid, in_addr, in_wdata, in_mem_read, in_mem_write, in_size,
           in_unsigned, in_rd, in_reg_write, flush, mem_rdata, mem_rdy,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           wb_valid, wb_data, wb_result, wb_rd, wb_reg_write, wb_err
  );

  modport slave (
    output in_valid, in_addr, in_wdata, in_mem_read, in_mem_write, in_size,
           in_unsigned, in_rd, in_reg_write, flush, mem_rdata, mem_rdy,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           wb_valid, wb_data, wb_result, wb_rd, wb_reg_write, wb_err
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: sized loads/stores over a request/ready port with wait states,
// load extension, misalignment detection, flush/kill and a registered writeback bundle.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_AW = 5
) (
  input  logic   clk,
  input  logic   rst,
  mem_wb_if.master bus
);
  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned LB = $clog2(NB);
  localparam int unsigned DW = DATA_W;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic                kill_q, kill_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic                rw_q, rw_d;

  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [NB-1:0]       mem_be_q, mem_be_d;

  logic                wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic [ADDR_W-1:0]   wb_result_q, wb_result_d;
  logic [REG_AW-1:0]   wb_rd_q, wb_rd_d;
  logic                wb_rw_q, wb_rw_d;
  logic                wb_err_q, wb_err_d;

  logic                in_ready_w, accept, is_mem, misaligned, kill_now;
  int unsigned         nb_in, lane_in, lane_c, bits, sa;
  logic [NB-1:0]       be_new;
  logic [DATA_W-1:0]   wdata_rep, shifted, tmp, load_ext;

  assign in_ready_w = (state_q == IDLE) && !rst;

  // Lane/enable/replication for the incoming access and extension of returning load data.
  always_comb begin
    nb_in   = 32'd1 << bus.in_size;
    lane_in = {{(32-LB){1'b0}}, bus.in_addr[LB-1:0]};
    be_new    = '0;
    wdata_rep = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      be_new[i]         = (i >= lane_in) && (i < lane_in + nb_in);
      wdata_rep[8*i +: 8] = bus.in_wdata[8*(i % nb_in) +: 8];
    end

    case (bus.in_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = bus.in_addr[0];
      2'b10:   misaligned = |bus.in_addr[1:0];
      default: misaligned = (DATA_W == 32) || (|bus.in_addr[2:0]);
    endcase

    lane_c  = {{(32-LB){1'b0}}, addr_q[LB-1:0]};
    shifted = bus.mem_rdata >> (8 * lane_c);
    bits    = 32'd8 << size_q;
    if (bits > DW) bits = DW;
    sa  = DW - bits;
    tmp = shifted << sa;
    // Left-justify then shift back: arithmetic shift sign-extends, logical zero-extends.
    if (uns_q) load_ext = tmp >> sa;
    else       load_ext = $signed(tmp) >>> sa;
  end

  always_comb begin
    accept   = bus.in_valid && in_ready_w && !bus.flush;
    is_mem   = bus.in_mem_read || bus.in_mem_write;
    kill_now = kill_q || bus.flush;

    state_d     = state_q;
    kill_d      = kill_q;
    addr_d      = addr_q;
    size_d      = size_q;
    uns_d       = uns_q;
    rd_d        = rd_q;
    rw_d        = rw_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    wb_valid_d  = 1'b0;
    wb_data_d   = wb_data_q;
    wb_result_d = wb_result_q;
    wb_rd_d     = wb_rd_q;
    wb_rw_d     = wb_rw_q;
    wb_err_d    = wb_err_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!is_mem) begin
            wb_valid_d  = 1'b1;
            wb_data_d   = DATA_W'(bus.in_addr);
            wb_result_d = bus.in_addr;
            wb_rd_d     = bus.in_rd;
            wb_rw_d     = bus.in_reg_write;
            wb_err_d    = 1'b0;
          end else if (misaligned) begin
            wb_valid_d  = 1'b1;
            wb_data_d   = '0;
            wb_result_d = bus.in_addr;
            wb_rd_d     = bus.in_rd;
            wb_rw_d     = 1'b0;
            wb_err_d    = 1'b1;
          end else begin
            state_d     = BUSY;
            kill_d      = 1'b0;
            addr_d      = bus.in_addr;
            size_d      = bus.in_size;
            uns_d       = bus.in_unsigned;
            rd_d        = bus.in_rd;
            rw_d        = bus.in_reg_write;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.in_mem_write;
            mem_addr_d  = bus.in_addr & ~ADDR_W'(NB - 1);
            mem_wdata_d = wdata_rep;
            mem_be_d    = be_new;
          end
        end
      end
      BUSY: begin
        if (bus.mem_rdy) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          kill_d    = 1'b0;
          if (!kill_now) begin
            wb_valid_d  = 1'b1;
            wb_data_d   = mem_we_q ? '0 : load_ext;
            wb_result_d = addr_q;
            wb_rd_d     = rd_q;
            wb_rw_d     = rw_q && !mem_we_q;
            wb_err_d    = 1'b0;
          end
        end else begin
          kill_d = kill_now;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      kill_q      <= 1'b0;
      addr_q      <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      rd_q        <= '0;
      rw_q        <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_result_q <= '0;
      wb_rd_q     <= '0;
      wb_rw_q     <= 1'b0;
      wb_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      kill_q      <= kill_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      rd_q        <= rd_d;
      rw_q        <= rw_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_result_q <= wb_result_d;
      wb_rd_q     <= wb_rd_d;
      wb_rw_q     <= wb_rw_d;
      wb_err_q    <= wb_err_d;
    end
  end

  assign bus.in_ready     = in_ready_w;
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.mem_be       = mem_be_q;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.wb_result    = wb_result_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_reg_write = wb_rw_q;
  assign bus.wb_err       = wb_err_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed vectors push expected memory requests and
// writebacks; negedge monitors pop and compare. A second 64-bit instance covers dword access.
module tb_mem_wb_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   wait_states = 0;

  always #5 clk = ~clk;

  mem_wb_if #(.DATA_W(32), .ADDR_W(32), .REG_AW(5)) bus ();
  mem_wb_if #(.DATA_W(64), .ADDR_W(32), .REG_AW(5)) b64 ();

  mem_wb_stage #(.DATA_W(32), .ADDR_W(32), .REG_AW(5)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  mem_wb_stage #(.DATA_W(64), .ADDR_W(32), .REG_AW(5)) u_dut64 (.clk(clk), .rst(rst), .bus(b64));

  typedef struct {
    logic [31:0] data;
    logic [31:0] result;
    logic [4:0]  rd;
    logic        rw;
    logic        err;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_exp_t;

  wb_exp_t  wbq[$];
  mem_exp_t memq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Writeback monitor
  always @(negedge clk) begin : wb_mon
    wb_exp_t e;
    if (!rst && bus.wb_valid === 1'b1) begin
      if (wbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL wb_unexpected: got wb_valid=1 rd=%0d expected no writeback", bus.wb_rd);
      end else begin
        e = wbq.pop_front();
        chk("wb_err", bus.wb_err, e.err);
        chk("wb_reg_write", bus.wb_reg_write, e.rw);
        chk("wb_rd", bus.wb_rd, e.rd);
        chk("wb_result", bus.wb_result, e.result);
        if (!e.err) chk("wb_data", bus.wb_data, e.data);
      end
    end
  end

  // Memory request monitor: checks the request on its first cycle and every held cycle
  logic     prev_req = 1'b0;
  logic     have_cur = 1'b0;
  mem_exp_t cur;
  always @(negedge clk) begin
    if (bus.mem_req === 1'b1) begin
      if (!prev_req) begin
        if (memq.size() == 0) begin
          checks++; errors++; have_cur = 1'b0;
          $display("FAIL mem_unexpected: got mem_req=1 addr=0x%0h expected no request", bus.mem_addr);
        end else begin
          cur = memq.pop_front(); have_cur = 1'b1;
        end
      end
      if (have_cur) begin
        chk("mem_we", bus.mem_we, cur.we);
        chk("mem_addr", bus.mem_addr, cur.addr);
        chk("mem_wdata", bus.mem_wdata, cur.wdata);
        chk("mem_be", bus.mem_be, cur.be);
      end
    end
    prev_req = (bus.mem_req === 1'b1);
  end

  // Memory responders
  initial begin : resp32
    int wcnt = 0;
    bus.mem_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) begin
        if (wcnt >= wait_states) begin bus.mem_rdy = 1'b1; wcnt = 0; end
        else begin bus.mem_rdy = 1'b0; wcnt++; end
      end else begin
        bus.mem_rdy = 1'b0; wcnt = 0;
      end
    end
  end

  initial begin : resp64
    b64.mem_rdy = 1'b0;
    forever begin
      @(negedge clk);
      b64.mem_rdy = (b64.mem_req === 1'b1);
    end
  end

  // mode: 0 normal, 1 flush while presenting in IDLE, 2 flush during BUSY
  task automatic run(input logic [31:0] addr, input logic [31:0] wdata, input logic rdop, input logic wrop,
                     input logic [1:0] size, input logic uns, input logic [4:0] rd, input logic rw,
                     input logic [31:0] rdata, input int waits, input int mode,
                     input logic exp_mem, input logic [31:0] exp_maddr, input logic [3:0] exp_be,
                     input logic [31:0] exp_wdata, input logic [31:0] exp_data,
                     input logic exp_rw, input logic exp_err);
    int cnt = 0;
    while (!bus.in_ready && cnt < 100) begin @(negedge clk); cnt++; end
    if (!bus.in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
    bus.mem_rdata = rdata; wait_states = waits;
    bus.in_valid = 1'b1; bus.in_addr = addr; bus.in_wdata = wdata;
    bus.in_mem_read = rdop; bus.in_mem_write = wrop; bus.in_size = size;
    bus.in_unsigned = uns; bus.in_rd = rd; bus.in_reg_write = rw;
    bus.flush = (mode == 1);
    if (mode != 1 && exp_mem) memq.push_back('{we: wrop, addr: exp_maddr, wdata: exp_wdata, be: exp_be});
    if (mode == 0) wbq.push_back('{data: exp_data, result: addr, rd: rd, rw: exp_rw, err: exp_err});
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_mem_read = 1'b0; bus.in_mem_write = 1'b0; bus.flush = 1'b0;
    if (exp_mem && mode != 1) begin
      if (mode == 2) bus.flush = 1'b1;
      cnt = 0;
      while (!bus.in_ready && cnt < 100) begin cnt++; @(negedge clk); bus.flush = 1'b0; end
      chk("busy_cycles", cnt, waits + 1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_mem_req"}, bus.mem_req, 0);
    chk({tag, "_mem_we"}, bus.mem_we, 0);
    chk({tag, "_mem_be"}, bus.mem_be, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_wb_valid"}, bus.wb_valid, 0);
    chk({tag, "_wb_data"}, bus.wb_data, 0);
    chk({tag, "_wb_result"}, bus.wb_result, 0);
    chk({tag, "_wb_rd"}, bus.wb_rd, 0);
    chk({tag, "_wb_reg_write"}, bus.wb_reg_write, 0);
    chk({tag, "_wb_err"}, bus.wb_err, 0);
  endtask

  task automatic run64(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                       input logic [63:0] rdata, input logic exp_err, input logic [31:0] exp_maddr,
                       input logic [7:0] exp_be, input logic [63:0] exp_data);
    b64.in_valid = 1'b1; b64.in_mem_read = 1'b1; b64.in_addr = addr; b64.in_size = size;
    b64.in_unsigned = uns; b64.in_rd = 5'd10; b64.in_reg_write = 1'b1; b64.mem_rdata = rdata;
    @(negedge clk);
    b64.in_valid = 1'b0; b64.in_mem_read = 1'b0;
    if (exp_err) begin
      chk("d64_err_mem_req", b64.mem_req, 0);
      chk("d64_err_wb_valid", b64.wb_valid, 1);
      chk("d64_err_wb_err", b64.wb_err, 1);
      chk("d64_err_wb_reg_write", b64.wb_reg_write, 0);
    end else begin
      chk("d64_mem_req", b64.mem_req, 1);
      chk("d64_mem_be", b64.mem_be, exp_be);
      chk("d64_mem_addr", b64.mem_addr, exp_maddr);
      @(negedge clk);
      chk("d64_wb_valid", b64.wb_valid, 1);
      chk("d64_wb_data", b64.wb_data, exp_data);
      chk("d64_wb_reg_write", b64.wb_reg_write, 1);
      chk("d64_wb_err", b64.wb_err, 0);
    end
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_wdata = '0; bus.in_mem_read = 1'b0;
    bus.in_mem_write = 1'b0; bus.in_size = '0; bus.in_unsigned = 1'b0; bus.in_rd = '0;
    bus.in_reg_write = 1'b0; bus.flush = 1'b0; bus.mem_rdata = '0;
    b64.in_valid = 1'b0; b64.in_addr = '0; b64.in_wdata = '0; b64.in_mem_read = 1'b0;
    b64.in_mem_write = 1'b0; b64.in_size = '0; b64.in_unsigned = 1'b0; b64.in_rd = '0;
    b64.in_reg_write = 1'b0; b64.flush = 1'b0; b64.mem_rdata = '0;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("reset_release_in_ready", bus.in_ready, 1);

    //   addr          wdata         rd wr sz  u  rd  rw  rdata         w  m  mem maddr        be     mwdata        wbdata        rw err
    run(32'h0000_1234, 32'h0,        0, 0, 2'd2, 0, 5'd3,  1, 32'h0,        0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0000_1234, 1, 0);
    run(32'hFFFF_0008, 32'h0,        0, 0, 2'd2, 0, 5'd31, 0, 32'h0,        0, 0, 0, 32'h0,        4'h0, 32'h0,        32'hFFFF_0008, 0, 0);
    run(32'h0000_0103, 32'h0,        1, 0, 2'd0, 0, 5'd5,  1, 32'h80FF_0000, 2, 0, 1, 32'h0000_0100, 4'h8, 32'h0,        32'hFFFF_FF80, 1, 0);
    run(32'h0000_0103, 32'h0,        1, 0, 2'd0, 1, 5'd6,  1, 32'h80FF_0000, 1, 0, 1, 32'h0000_0100, 4'h8, 32'h0,        32'h0000_0080, 1, 0);
    run(32'h0000_0102, 32'h1234_ABCD, 0, 1, 2'd1, 0, 5'd7,  1, 32'h0,        0, 0, 1, 32'h0000_0100, 4'hC, 32'hABCD_ABCD, 32'h0,        0, 0);
    run(32'h0000_0102, 32'h0,        1, 0, 2'd2, 0, 5'd8,  1, 32'h0,        0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0,        0, 1);
    run(32'h0000_0102, 32'h0,        1, 0, 2'd1, 0, 5'd9,  1, 32'h8001_7FFF, 0, 0, 1, 32'h0000_0100, 4'hC, 32'h0,        32'hFFFF_8001, 1, 0);
    run(32'h0000_0104, 32'h0,        1, 0, 2'd2, 0, 5'd10, 1, 32'hDEAD_BEEF, 3, 0, 1, 32'h0000_0104, 4'hF, 32'h0,        32'hDEAD_BEEF, 1, 0);
    run(32'h0000_0101, 32'h0000_005A, 0, 1, 2'd0, 0, 5'd11, 0, 32'h0,        1, 0, 1, 32'h0000_0100, 4'h2, 32'h5A5A_5A5A, 32'h0,        0, 0);
    run(32'h0000_0008, 32'h0,        1, 0, 2'd3, 0, 5'd12, 1, 32'h0,        0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0,        0, 1);
    run(32'h0000_0101, 32'h0,        1, 0, 2'd1, 1, 5'd13, 1, 32'h0,        0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0,        0, 1);
    run(32'h0000_7777, 32'h0,        0, 0, 2'd2, 0, 5'd14, 1, 32'h0,        0, 1, 0, 32'h0,        4'h0, 32'h0,        32'h0,        0, 0);
    run(32'h0000_0100, 32'h0,        1, 0, 2'd2, 0, 5'd15, 1, 32'h1111_2222, 3, 2, 1, 32'h0000_0100, 4'hF, 32'h0,        32'h0,        0, 0);
    run(32'h0000_4321, 32'h0,        0, 0, 2'd2, 0, 5'd9,  1, 32'h0,        0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0000_4321, 1, 0);

    // Reset while a long-latency load is outstanding: request abandoned, no writeback
    bus.mem_rdata = 32'hCAFE_F00D; wait_states = 50;
    bus.in_valid = 1'b1; bus.in_addr = 32'h0000_0200; bus.in_wdata = '0; bus.in_mem_read = 1'b1;
    bus.in_size = 2'd2; bus.in_unsigned = 1'b0; bus.in_rd = 5'd4; bus.in_reg_write = 1'b1;
    memq.push_back('{we: 1'b0, addr: 32'h0000_0200, wdata: 32'h0, be: 4'hF});
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_mem_read = 1'b0;
    @(negedge clk);
    chk("busy_before_rst_mem_req", bus.mem_req, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_busy");
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy_release_in_ready", bus.in_ready, 1);

    run(32'h0000_0055, 32'h0, 0, 0, 2'd2, 0, 5'd1, 1, 32'h0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0000_0055, 1, 0);

    //    addr          sz  u  rdata                    err maddr         be     wbdata
    run64(32'h0000_0008, 2'd3, 0, 64'h1122_3344_5566_7788, 0, 32'h0000_0008, 8'hFF, 64'h1122_3344_5566_7788);
    run64(32'h0000_000C, 2'd2, 0, 64'h8000_0001_0000_0000, 0, 32'h0000_0008, 8'hF0, 64'hFFFF_FFFF_8000_0001);
    run64(32'h0000_000E, 2'd1, 1, 64'hBEEF_0000_0000_0000, 0, 32'h0000_0008, 8'hC0, 64'h0000_0000_0000_BEEF);
    run64(32'h0000_0004, 2'd3, 0, 64'h0,                   1, 32'h0,         8'h00, 64'h0);

    repeat (5) @(negedge clk);
    chk("wb_queue_empty", wbq.size(), 0);
    chk("mem_queue_empty", memq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
